// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between fetch and decode. Holds up to DEPTH fetched
// {pc, instruction} pairs in a circular buffer with valid/ready handshakes on
// both sides. A taken-branch flush discards every buffered entry. The head
// entry is presented to decode together with its pc+4 and an alignment flag.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low; clears count and pointers
//   in_valid       fetch presents in_pc/in_instr this cycle
//   in_pc          address of fetched instruction
//   in_instr       fetched instruction word
//   in_ready       queue can accept a push this cycle (count < DEPTH)
//   flush          taken branch: discard all contents at the next edge
//   out_valid      head entry is valid (count != 0)
//   out_pc         pc of head entry (0 when empty)
//   out_instr      instruction of head entry (0 when empty)
//   out_pc_next    out_pc + 4, wrapping at DATA_W (0 when empty)
//   out_misaligned head pc[1:0] != 0 (0 when empty)
//   out_ready      decode consumes the head entry this cycle
//   count          number of valid entries
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instr,
    output logic [DATA_W-1:0]          out_pc_next,
    output logic                       out_misaligned,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    // Both handshakes look only at the registered count, so in_ready never
    // combinationally depends on out_ready.
    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            // Flush wins over any push/pop presented in the same cycle.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through rd_ptr while
    // count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // An empty queue drives an all-zero bubble to decode.
    assign out_pc         = out_valid ? head_pc : '0;
    assign out_instr      = out_valid ? head_instr : '0;
    assign out_pc_next    = out_valid ? (head_pc + DATA_W'(4)) : '0;
    assign out_misaligned = out_valid && (head_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_instr;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc_next;
    logic              out_misaligned;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {pc, instr} of every accepted push, in FIFO order.
    logic [2*DATA_W-1:0] sb[$];

    if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_pc_next(out_pc_next),
        .out_misaligned(out_misaligned),
        .out_ready(out_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [DATA_W-1:0] pc,
                         input logic [DATA_W-1:0] instr, input logic rdy,
                         input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance one edge; the scoreboard follows the handshake rules from the
    // bench's own view of occupancy, then outputs settle 1 time unit later.
    task automatic step();
        bit do_push;
        bit do_pop;
        logic [2*DATA_W-1:0] d;
        do_push = in_valid && (sb.size() < DEPTH);
        do_pop  = out_ready && (sb.size() != 0);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) d = sb.pop_front();
            if (do_push) sb.push_back({in_pc, in_instr});
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 0, 0);
        reset = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b count=%0d, want 0 1 0",
                     out_valid, in_ready, count);
        end
        checks++;
        if (out_pc !== '0 || out_instr !== '0 || out_pc_next !== '0 || out_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: pc=%h instr=%h next=%h mis=%b, want zeros",
                     out_pc, out_instr, out_pc_next, out_misaligned);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_push();
        logic [2*DATA_W-1:0] exp;
        drive(1, 32'h10, 32'hDEADBEEF, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        exp = sb[0];
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp[2*DATA_W-1:DATA_W] || out_pc !== 32'h10) begin
            errors++;
            $display("FAIL single_pc: valid=%b pc=%h, want 1 00000010", out_valid, out_pc);
        end
        checks++;
        if (out_instr !== exp[DATA_W-1:0] || out_instr !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_instr: got %h want deadbeef", out_instr);
        end
        checks++;
        if (out_pc_next !== 32'h14 || count !== CNT_W'(1) || out_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL single_next: next=%h count=%0d mis=%b, want 00000014 1 0",
                     out_pc_next, count, out_misaligned);
        end
        // Drain
        drive(0, '0, '0, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL single_drain: valid=%b count=%0d, want 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            drive(1, pcs[i], 32'hA000_0000 | pcs[i], 0, 0);
            step();
            if (i >= 1) begin
                checks++;
                if (count !== CNT_W'(2) || in_ready !== 1'b0 || out_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL fill_full[%0d]: count=%0d in_ready=%b pc=%h, want 2 0 00000000",
                             i, count, in_ready, out_pc);
                end
            end
        end
        // Drain and compare against scoreboard order
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== sb[0][2*DATA_W-1:DATA_W]
                || out_instr !== sb[0][DATA_W-1:0]) begin
                errors++;
                $display("FAIL fill_drain[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                         i, out_valid, out_pc, out_instr,
                         sb[0][2*DATA_W-1:DATA_W], sb[0][DATA_W-1:0]);
            end
            step();
            checks++;
            if (count !== CNT_W'(1 - i)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, 1 - i);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL fill_empty: valid=%b sb=%0d, want 0 0", out_valid, sb.size());
        end
        // Pop on empty must not underflow.
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop: count=%0d in_ready=%b, want 0 1", count, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h20, 32'h1111_0020, 0, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'h24 + 32'(4 * k), 32'h1111_0024 + 32'(4 * k), 1, 0);
            step();
            checks++;
            if (count !== CNT_W'(1) || out_pc !== (32'h24 + 32'(4 * k))
                || out_instr !== sb[0][DATA_W-1:0]) begin
                errors++;
                $display("FAIL b2b[%0d]: count=%0d pc=%h instr=%h, want 1 %h %h",
                         k, count, out_pc, out_instr, 32'h24 + 32'(4 * k), sb[0][DATA_W-1:0]);
            end
        end
        drive(0, '0, '0, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL b2b_drain: count=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h100, 32'hB100, 0, 0);
        step();
        drive(1, 32'h104, 32'hB104, 0, 0);
        step();
        drive(1, 32'h108, 32'hB108, 1, 1);
        step();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || out_instr !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: count=%0d valid=%b instr=%h in_ready=%b, want 0 0 0 1",
                     count, out_valid, out_instr, in_ready);
        end
        // Flush with room available: the simultaneous push must be dropped.
        drive(1, 32'h300, 32'hC300, 0, 0);
        step();
        drive(1, 32'h304, 32'hC304, 0, 1);
        step();
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_push: count=%0d valid=%b, want 0 0", count, out_valid);
        end
        drive(1, 32'h200, 32'hB200, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (count !== CNT_W'(1) || out_pc !== 32'h200 || out_instr !== 32'hB200) begin
            errors++;
            $display("FAIL flush_after: count=%0d pc=%h instr=%h, want 1 00000200 0000b200",
                     count, out_pc, out_instr);
        end
        drive(0, '0, '0, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_boundaries();
        drive(1, 32'hFFFF_FFFC, 32'h0000_0013, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (out_pc_next !== 32'h0 || out_misaligned !== 1'b0 || out_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_next: pc=%h next=%h mis=%b, want fffffffc 00000000 0",
                     out_pc, out_pc_next, out_misaligned);
        end
        drive(1, 32'h6, 32'h0000_0033, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (out_pc !== 32'h6 || out_misaligned !== 1'b1 || out_pc_next !== 32'hA) begin
            errors++;
            $display("FAIL misaligned: pc=%h mis=%b next=%h, want 00000006 1 0000000a",
                     out_pc, out_misaligned, out_pc_next);
        end
        drive(0, '0, '0, 1, 0);
        step();
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h40, 32'hD040, 0, 0);
        step();
        drive(1, 32'h44, 32'hD044, 0, 0);
        step();
        checks++;
        if (count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL premid_count: got %0d want 2", count);
        end
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 || out_pc !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b count=%0d in_ready=%b pc=%h, want 0 0 1 0",
                     out_valid, count, in_ready, out_pc);
        end
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 32'h0, 32'hE000, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hE000 || count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL post_reset_push: valid=%b pc=%h instr=%h count=%0d, want 1 0 e000 1",
                     out_valid, out_pc, out_instr, count);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, '0, 0, 0);
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flush();
        test_boundaries();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
